// File: rtl/snn_pkg.sv
// Shared types and helpers for the LIF neuron: state encoding, ceil-log2
// and a clamp used to saturate the membrane potential.
package snn_pkg;

  typedef enum logic {
    ST_INTEG  = 1'b0,
    ST_REFRAC = 1'b1
  } state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  // Clamp x into the signed range representable with w bits.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] x,
                                                  input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

endpackage

// File: rtl/snn_lif_array_neuron_if.sv
// Per-neuron bus: timestep strobe, synapse inputs, configuration and
// neuron outputs. The layer drives through master; the neuron sits on slave.
interface snn_lif_array_neuron_if #(
  parameter int N_IN         = 4,
  parameter int WEIGHT_WIDTH = 4,
  parameter int POT_WIDTH    = 8,
  parameter int REFRAC_WIDTH = 3
);
  logic                           step_en;
  logic [N_IN-1:0]                spike_in;
  logic [N_IN*WEIGHT_WIDTH-1:0]   weights;
  logic signed [POT_WIDTH-1:0]    threshold;
  logic [POT_WIDTH-2:0]           leak;
  logic [REFRAC_WIDTH-1:0]        refrac_len;
  logic                           spike_out;
  logic signed [POT_WIDTH-1:0]    v_mem;
  logic                           refractory;

  modport master (
    output step_en, spike_in, weights, threshold, leak, refrac_len,
    input  spike_out, v_mem, refractory
  );

  modport slave (
    input  step_en, spike_in, weights, threshold, leak, refrac_len,
    output spike_out, v_mem, refractory
  );
endinterface

// File: rtl/snn_weighted_sum.sv
// Combinational sum of the weights whose synapse spiked this timestep,
// sign-extended wide enough that no combination can overflow.
module snn_weighted_sum
  import snn_pkg::*;
#(
  parameter int N_IN         = 4,
  parameter int WEIGHT_WIDTH = 4,
  parameter int SUM_WIDTH    = WEIGHT_WIDTH + clog2(N_IN)
) (
  input  logic [N_IN-1:0]              spike_in,
  input  logic [N_IN*WEIGHT_WIDTH-1:0] weights,
  output logic signed [SUM_WIDTH-1:0]  sum
);

  logic signed [SUM_WIDTH-1:0] term [N_IN];

  genvar gi;
  generate
    for (gi = 0; gi < N_IN; gi++) begin : g_term
      logic signed [WEIGHT_WIDTH-1:0] w_i;
      assign w_i      = weights[gi*WEIGHT_WIDTH +: WEIGHT_WIDTH];
      assign term[gi] = spike_in[gi] ? SUM_WIDTH'(w_i) : '0;
    end
  endgenerate

  always_comb begin
    sum = '0;
    for (int i = 0; i < N_IN; i++) begin
      sum = sum + term[i];
    end
  end

endmodule

// File: rtl/snn_lif_array_neuron.sv
// Leaky integrate-and-fire neuron: leak toward zero, add weighted input,
// saturate, fire on threshold, then optionally sit out a refractory period.
module snn_lif_array_neuron
  import snn_pkg::*;
#(
  parameter int N_IN         = 4,
  parameter int WEIGHT_WIDTH = 4,
  parameter int POT_WIDTH    = 8,
  parameter int REFRAC_WIDTH = 3
) (
  input  logic                 CLK,
  input  logic                 nRST,
  snn_lif_array_neuron_if.slave bus
);

  localparam int SUM_W = WEIGHT_WIDTH + clog2(N_IN);
  localparam int EXT_W = POT_WIDTH + clog2(N_IN) + 1;

  state_e                      state_q, state_d;
  logic signed [POT_WIDTH-1:0] v_q, v_d;
  logic [REFRAC_WIDTH-1:0]     cnt_q, cnt_d;
  logic                        spike_q, spike_d;

  logic signed [SUM_W-1:0]     sum_w;
  logic signed [EXT_W-1:0]     v_ext, leak_ext, sum_ext, v_leak, v_raw;
  logic signed [POT_WIDTH-1:0] v_sat, thr;
  logic                        fire;

  snn_weighted_sum #(
    .N_IN        (N_IN),
    .WEIGHT_WIDTH(WEIGHT_WIDTH),
    .SUM_WIDTH   (SUM_W)
  ) u_sum (
    .spike_in(bus.spike_in),
    .weights (bus.weights),
    .sum     (sum_w)
  );

  assign thr = bus.threshold;

  // Leak saturates at zero instead of crossing it, so clamp the step to |v|.
  always_comb begin
    v_ext    = EXT_W'(v_q);
    leak_ext = EXT_W'(bus.leak);
    sum_ext  = EXT_W'(sum_w);
    v_leak   = '0;
    if (v_ext > 0) begin
      v_leak = (v_ext > leak_ext) ? (v_ext - leak_ext) : '0;
    end else if (v_ext < 0) begin
      v_leak = (-v_ext > leak_ext) ? (v_ext + leak_ext) : '0;
    end
    v_raw = v_leak + sum_ext;
    v_sat = POT_WIDTH'(saturate(64'(v_raw), POT_WIDTH));
    fire  = (v_sat >= thr);
  end

  always_comb begin
    state_d = state_q;
    v_d     = v_q;
    cnt_d   = cnt_q;
    spike_d = 1'b0;
    if (bus.step_en) begin
      case (state_q)
        ST_INTEG: begin
          if (fire) begin
            spike_d = 1'b1;
            v_d     = '0;
            if (bus.refrac_len != '0) begin
              state_d = ST_REFRAC;
              cnt_d   = bus.refrac_len;
            end
          end else begin
            v_d = v_sat;
          end
        end
        ST_REFRAC: begin
          v_d   = '0;
          cnt_d = cnt_q - REFRAC_WIDTH'(1);
          if (cnt_q <= REFRAC_WIDTH'(1)) begin
            state_d = ST_INTEG;
            cnt_d   = '0;
          end
        end
        default: state_d = ST_INTEG;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= ST_INTEG;
      v_q     <= '0;
      cnt_q   <= '0;
      spike_q <= 1'b0;
    end else begin
      state_q <= state_d;
      v_q     <= v_d;
      cnt_q   <= cnt_d;
      spike_q <= spike_d;
    end
  end

  assign bus.spike_out  = spike_q;
  assign bus.v_mem      = v_q;
  assign bus.refractory = (state_q == ST_REFRAC);

endmodule

// File: tb/tb_snn_lif_array_neuron.sv
// Directed bench for the LIF neuron: integrate/fire, leak, saturation,
// refractory, step gating, zero threshold and asynchronous reset.
module tb_snn_lif_array_neuron;

  logic CLK;
  logic nRST;
  int   n_vec;
  int   n_err;

  snn_lif_array_neuron_if #(
    .N_IN(4), .WEIGHT_WIDTH(4), .POT_WIDTH(8), .REFRAC_WIDTH(3)
  ) bus ();

  snn_lif_array_neuron #(
    .N_IN(4), .WEIGHT_WIDTH(4), .POT_WIDTH(8), .REFRAC_WIDTH(3)
  ) dut (
    .CLK (CLK),
    .nRST(nRST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk3(input string tag, input int v, input int s, input int r);
    $display("%s: v_mem=%0d spike_out=%0d refractory=%0d", tag,
             int'(bus.v_mem), int'(bus.spike_out), int'(bus.refractory));
    chk({tag, ".v_mem"}, int'(bus.v_mem), v);
    chk({tag, ".spike_out"}, int'(bus.spike_out), s);
    chk({tag, ".refractory"}, int'(bus.refractory), r);
  endtask

  task automatic do_step();
    @(negedge CLK);
    bus.step_en = 1'b1;
    @(posedge CLK);
    #1;
    bus.step_en = 1'b0;
  endtask

  task automatic idle();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    nRST = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    nRST  = 1'b0;
    bus.step_en    = 1'b0;
    bus.spike_in   = '0;
    bus.weights    = '0;
    bus.threshold  = '0;
    bus.leak       = '0;
    bus.refrac_len = '0;
    repeat (2) @(negedge CLK);
    chk3("reset", 0, 0, 0);
    nRST = 1'b1;

    // Integrate and fire every second step
    bus.threshold = 8'sd10;
    bus.weights   = 16'h0043;
    bus.spike_in  = 4'b0011;
    do_step(); chk3("int1", 7, 0, 0);
    do_step(); chk3("fire1", 0, 1, 0);
    do_step(); chk3("int2", 7, 0, 0);
    do_step(); chk3("fire2", 0, 1, 0);

    // step_en low: spike pulse drops, potential holds
    idle();    chk3("gate_clr", 0, 0, 0);
    do_step(); chk3("int3", 7, 0, 0);
    idle();    chk3("gate1", 7, 0, 0);
    idle();    chk3("gate2", 7, 0, 0);
    idle();    chk3("gate3", 7, 0, 0);

    // Zero threshold fires every step, even from v=0 with no input
    bus.threshold = 8'sd0;
    bus.spike_in  = 4'b0000;
    do_step(); chk3("thr0_a", 0, 1, 0);
    do_step(); chk3("thr0_b", 0, 1, 0);

    // Leak toward zero from +5
    do_reset();
    bus.threshold = 8'sd127;
    bus.weights   = 16'h0005;
    bus.spike_in  = 4'b0001;
    do_step(); chk3("pre_pos", 5, 0, 0);
    bus.leak     = 7'd2;
    bus.spike_in = 4'b0000;
    do_step(); chk3("leak_p1", 3, 0, 0);
    do_step(); chk3("leak_p2", 1, 0, 0);
    do_step(); chk3("leak_p3", 0, 0, 0);
    do_step(); chk3("leak_p4", 0, 0, 0);

    // Leak toward zero from -5
    do_reset();
    bus.leak     = 7'd0;
    bus.weights  = 16'h000B;
    bus.spike_in = 4'b0001;
    do_step(); chk3("pre_neg", -5, 0, 0);
    bus.leak     = 7'd2;
    bus.spike_in = 4'b0000;
    do_step(); chk3("leak_n1", -3, 0, 0);
    do_step(); chk3("leak_n2", -1, 0, 0);
    do_step(); chk3("leak_n3", 0, 0, 0);

    // Positive saturation reaches the maximum threshold
    do_reset();
    bus.leak     = 7'd0;
    bus.weights  = 16'h7777;
    bus.spike_in = 4'b1111;
    do_step(); chk3("satp1", 28, 0, 0);
    do_step(); chk3("satp2", 56, 0, 0);
    do_step(); chk3("satp3", 84, 0, 0);
    do_step(); chk3("satp4", 112, 0, 0);
    do_step(); chk3("satp5", 0, 1, 0);

    // Negative saturation holds at the minimum
    do_reset();
    bus.weights = 16'h8888;
    do_step(); chk3("satn1", -32, 0, 0);
    do_step(); chk3("satn2", -64, 0, 0);
    do_step(); chk3("satn3", -96, 0, 0);
    do_step(); chk3("satn4", -128, 0, 0);
    do_step(); chk3("satn5", -128, 0, 0);

    // Refractory: running counter ignores a mid-period refrac_len change
    do_reset();
    bus.threshold  = 8'sd5;
    bus.weights    = 16'h0007;
    bus.spike_in   = 4'b0001;
    bus.refrac_len = 3'd2;
    do_step(); chk3("ref_fire", 0, 1, 1);
    bus.refrac_len = 3'd7;
    do_step(); chk3("ref_1", 0, 0, 1);
    do_step(); chk3("ref_2", 0, 0, 0);
    do_step(); chk3("ref_refire", 0, 1, 1);

    // Asynchronous reset between edges while refractory
    do_reset();
    bus.refrac_len = 3'd3;
    do_step(); chk3("ar_fire", 0, 1, 1);
    #2 nRST = 1'b0;
    #1 chk3("ar_async", 0, 0, 0);
    @(negedge CLK);
    nRST = 1'b1;
    bus.threshold = 8'sd10;
    do_step(); chk3("ar_int", 7, 0, 0);
    do_step(); chk3("ar_fire2", 0, 1, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
